// File: rtl/my_divider_if.sv
// Start/done handshake and operand/result bus between the ALU control and my_divider.
interface my_divider_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/my_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, WIDTH steps per division.
// A zero divisor short-circuits to DONE with all-ones quotient and the dividend as remainder.
module my_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  my_divider_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_div, r_rem, r_q;
  logic [WIDTH-1:0] r_quot, r_remd;
  logic [CW-1:0]    r_cnt;
  logic             r_dbz;

  logic [WIDTH:0]   w_s;
  logic [WIDTH-1:0] w_t;
  logic             w_borrow, w_carry;
  logic [WIDTH-1:0] w_rem_nx, w_q_nx;
  logic             w_accept, w_zero, w_last;

  assign w_s = {r_rem, r_q[WIDTH-1]};
  // S's MSB set means S >= 2^WIDTH > divisor, so the low-WIDTH difference is exact
  // and the WIDTH+1-bit compare reduces to MSB | no-borrow.
  assign {w_borrow, w_t} = {1'b0, w_s[WIDTH-1:0]} - {1'b0, r_div};
  assign w_carry  = w_s[WIDTH] | ~w_borrow;
  assign w_rem_nx = w_carry ? w_t : w_s[WIDTH-1:0];
  assign w_q_nx   = {r_q[WIDTH-2:0], w_carry};

  assign w_accept = bus.start && (r_state != RUN);
  assign w_zero   = (bus.divisor == '0);
  assign w_last   = (r_cnt == CW'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept) w_next = w_zero ? DONE : RUN;
        else          w_next = IDLE;
      end
      RUN:     if (w_last) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_remd <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      if (w_zero) begin
        r_quot <= '1;
        r_remd <= bus.dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_div <= bus.divisor;
        r_rem <= '0;
        r_q   <= bus.dividend;
        r_cnt <= CW'(WIDTH);
        r_dbz <= 1'b0;
      end
    end else if (r_state == RUN) begin
      r_rem <= w_rem_nx;
      r_q   <= w_q_nx;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_quot <= w_q_nx;
        r_remd <= w_rem_nx;
      end
    end
  end

  assign bus.busy        = (r_state == RUN);
  assign bus.done        = (r_state == DONE);
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_remd;
  assign bus.div_by_zero = r_dbz;
endmodule
